// File: rtl/fphub_div_sequencer.sv
// Control FSM for the FPHUB divider: operand handshake, special-case classification,
// iterative mantissa sequencing and result handshake. Optional macro: FPHUB_DIV_INVALID_FLAG_EN.
module fphub_div_sequencer #(
    parameter int M            = 23,
    parameter int E            = 8,
    parameter int SPECIAL_CASE = 7,
    parameter int ITERS        = M + 2,
    localparam int SCW         = $clog2(SPECIAL_CASE),
    localparam int CW          = $clog2(ITERS + 1)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic           x_sign,
    input  logic           y_sign,
    input  logic [SCW-1:0] x_sc,
    input  logic [SCW-1:0] y_sc,
    output logic           op_load,
    output logic           iter_en,
    output logic [CW-1:0]  iter_cnt,
    output logic           norm_en,
    output logic [1:0]     res_sel,
    output logic           res_sign,
`ifdef FPHUB_DIV_INVALID_FLAG_EN
    output logic           invalid,
`endif
    output logic           out_valid,
    input  logic           out_ready
);

    if (ITERS < 1 || E < 1) begin : g_bad_cfg
        $error("fphub_div_sequencer: ITERS and E must be >= 1");
    end

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_CLASSIFY = 3'd1,
        S_ITER     = 3'd2,
        S_NORM     = 3'd3,
        S_SPECIAL  = 3'd4,
        S_DONE     = 3'd5
    } state_t;

    localparam logic [SCW-1:0] SC_PINF  = SCW'(1);
    localparam logic [SCW-1:0] SC_NINF  = SCW'(2);
    localparam logic [SCW-1:0] SC_PZERO = SCW'(3);
    localparam logic [SCW-1:0] SC_NZERO = SCW'(4);
    localparam logic [SCW-1:0] SC_PONE  = SCW'(5);
    localparam logic [SCW-1:0] SC_NONE1 = SCW'(6);
    localparam logic [1:0] SEL_QUO  = 2'd0;
    localparam logic [1:0] SEL_INF  = 2'd1;
    localparam logic [1:0] SEL_ZERO = 2'd2;
    localparam logic [1:0] SEL_PASS = 2'd3;
    localparam logic [CW-1:0] LAST_ITER = CW'(ITERS - 1);

    // Undefined codes match none of these, so they fall through to "no special case".
    function automatic logic is_inf(input logic [SCW-1:0] c);
        return (c == SC_PINF) || (c == SC_NINF);
    endfunction

    function automatic logic is_zero(input logic [SCW-1:0] c);
        return (c == SC_PZERO) || (c == SC_NZERO);
    endfunction

    function automatic logic is_one(input logic [SCW-1:0] c);
        return (c == SC_PONE) || (c == SC_NONE1);
    endfunction

    function automatic logic [1:0] class_sel(input logic [SCW-1:0] xc, input logic [SCW-1:0] yc);
        if ((is_zero(xc) && is_zero(yc)) || (is_inf(xc) && is_inf(yc))) return SEL_INF;
        else if (is_inf(xc) || is_zero(yc)) return SEL_INF;
        else if (is_zero(xc) || is_inf(yc)) return SEL_ZERO;
        else if (is_one(yc)) return SEL_PASS;
        else return SEL_QUO;
    endfunction

`ifdef FPHUB_DIV_INVALID_FLAG_EN
    function automatic logic class_rule1(input logic [SCW-1:0] xc, input logic [SCW-1:0] yc);
        return (is_zero(xc) && is_zero(yc)) || (is_inf(xc) && is_inf(yc));
    endfunction
    logic r_rule1, w_rule1_nxt, r_invalid;
`endif

    state_t         r_state, w_next_state;
    logic [SCW-1:0] r_x_sc, r_y_sc;
    logic [CW-1:0]  r_iter_cnt, w_iter_cnt_nxt;
    logic [1:0]     r_res_sel, w_res_sel_nxt;
    logic           r_res_sign, r_in_ready, r_op_load, r_iter_en, r_norm_en, r_out_valid;
    logic           w_accept;

    assign w_accept = in_valid & r_in_ready;

    // Next-state and next-value logic; every output register is loaded from the next state.
    always_comb begin
        w_next_state   = r_state;
        w_iter_cnt_nxt = {CW{1'b0}};
        w_res_sel_nxt  = r_res_sel;
`ifdef FPHUB_DIV_INVALID_FLAG_EN
        w_rule1_nxt    = r_rule1;
`endif
        case (r_state)
            S_IDLE: begin
                if (w_accept) w_next_state = S_CLASSIFY;
                else          w_next_state = S_IDLE;
            end
            S_CLASSIFY: begin
                w_res_sel_nxt = class_sel(r_x_sc, r_y_sc);
`ifdef FPHUB_DIV_INVALID_FLAG_EN
                w_rule1_nxt   = class_rule1(r_x_sc, r_y_sc);
`endif
                if (class_sel(r_x_sc, r_y_sc) == SEL_QUO) w_next_state = S_ITER;
                else                                      w_next_state = S_SPECIAL;
            end
            S_ITER: begin
                if (r_iter_cnt == LAST_ITER) begin
                    w_next_state = S_NORM;
                end else begin
                    w_iter_cnt_nxt = r_iter_cnt + CW'(1);
                end
            end
            S_NORM:    w_next_state = S_DONE;
            S_SPECIAL: w_next_state = S_DONE;
            S_DONE: begin
                if (out_ready) begin
                    w_next_state = S_IDLE;
`ifdef FPHUB_DIV_INVALID_FLAG_EN
                    w_rule1_nxt  = 1'b0;
`endif
                end else begin
                    w_next_state = S_DONE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next_state;
    end

    // Registered outputs, aligned with the state they describe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_in_ready  <= 1'b1;
            r_op_load   <= 1'b0;
            r_iter_en   <= 1'b0;
            r_iter_cnt  <= {CW{1'b0}};
            r_norm_en   <= 1'b0;
            r_res_sel   <= 2'd0;
            r_out_valid <= 1'b0;
        end else begin
            r_in_ready  <= (w_next_state == S_IDLE);
            r_op_load   <= (r_state == S_IDLE) && w_accept;
            r_iter_en   <= (w_next_state == S_ITER);
            r_iter_cnt  <= w_iter_cnt_nxt;
            r_norm_en   <= (w_next_state == S_NORM);
            r_res_sel   <= w_res_sel_nxt;
            r_out_valid <= (w_next_state == S_DONE);
        end
    end

    // Operand capture at accept; nothing is re-sampled until the next accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x_sc     <= {SCW{1'b0}};
            r_y_sc     <= {SCW{1'b0}};
            r_res_sign <= 1'b0;
        end else if ((r_state == S_IDLE) && w_accept) begin
            r_x_sc     <= x_sc;
            r_y_sc     <= y_sc;
            r_res_sign <= x_sign ^ y_sign;
        end else begin
            r_x_sc     <= r_x_sc;
            r_y_sc     <= r_y_sc;
            r_res_sign <= r_res_sign;
        end
    end

`ifdef FPHUB_DIV_INVALID_FLAG_EN
    // Invalid-operation flag: remembered from classification, shown only in DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rule1   <= 1'b0;
            r_invalid <= 1'b0;
        end else begin
            r_rule1   <= w_rule1_nxt;
            r_invalid <= (w_next_state == S_DONE) && w_rule1_nxt;
        end
    end
    assign invalid = r_invalid;
`endif

    assign in_ready  = r_in_ready;
    assign op_load   = r_op_load;
    assign iter_en   = r_iter_en;
    assign iter_cnt  = r_iter_cnt;
    assign norm_en   = r_norm_en;
    assign res_sel   = r_res_sel;
    assign res_sign  = r_res_sign;
    assign out_valid = r_out_valid;

endmodule

// File: tb/tb_fphub_div_sequencer.sv
// Directed, table-driven bench for fphub_div_sequencer (default ITERS = 25).
module tb_fphub_div_sequencer;

    logic       clk = 1'b0;
    logic       rst_n, in_valid, in_ready, x_sign, y_sign;
    logic [2:0] x_sc, y_sc;
    logic       op_load, iter_en, norm_en, res_sign, out_valid, out_ready;
    logic [4:0] iter_cnt;
    logic [1:0] res_sel;
`ifdef FPHUB_DIV_INVALID_FLAG_EN
    logic       invalid;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    fphub_div_sequencer dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .x_sign(x_sign), .y_sign(y_sign), .x_sc(x_sc), .y_sc(y_sc),
        .op_load(op_load), .iter_en(iter_en), .iter_cnt(iter_cnt), .norm_en(norm_en),
        .res_sel(res_sel), .res_sign(res_sign),
`ifdef FPHUB_DIV_INVALID_FLAG_EN
        .invalid(invalid),
`endif
        .out_valid(out_valid), .out_ready(out_ready)
    );

    typedef struct {
        logic       xs;
        logic       ys;
        logic [2:0] xc;
        logic [2:0] yc;
        logic [1:0] sel;
        logic       sign;
        int         lat;
        int         iters;
        logic       inv;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic start_pair(input logic xs, input logic ys, input logic [2:0] xc, input logic [2:0] yc);
        @(negedge clk);
        x_sign = xs; y_sign = ys; x_sc = xc; y_sc = yc; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Runs one pair up to the first out_valid sample, leaving the result held in DONE.
    task automatic run_to_done(input vec_t v, input string tag);
        int   lat, iters, norms, loads;
        logic seq_ok;
        check({tag, "_in_ready_pre"}, 32'(in_ready), 32'd1);
        start_pair(v.xs, v.ys, v.xc, v.yc);
        lat = 1; iters = 0; norms = 0; loads = 0; seq_ok = 1'b1;
        while (!out_valid && lat < 60) begin
            if (op_load) loads++;
            if (iter_en) begin
                if (iter_cnt !== 5'(iters)) seq_ok = 1'b0;
                iters++;
            end else if (iter_cnt !== 5'd0) begin
                seq_ok = 1'b0;
            end
            if (norm_en) begin
                norms++;
                if (iters != v.iters) seq_ok = 1'b0;
            end
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, "_latency"},   32'(lat), 32'(v.lat));
        check({tag, "_out_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_res_sel"},   32'(res_sel), 32'(v.sel));
        check({tag, "_res_sign"},  32'(res_sign), 32'(v.sign));
        check({tag, "_iter_cnt"},  32'(iters), 32'(v.iters));
        check({tag, "_norm_cnt"},  32'(norms), (v.iters > 0) ? 32'd1 : 32'd0);
        check({tag, "_op_load"},   32'(loads), 32'd1);
        check({tag, "_iter_seq"},  32'(seq_ok), 32'd1);
        check({tag, "_done_strb"}, 32'({op_load, iter_en, norm_en, in_ready}), 32'd0);
`ifdef FPHUB_DIV_INVALID_FLAG_EN
        check({tag, "_invalid"},   32'(invalid), 32'(v.inv));
`endif
    endtask

    task automatic handshake(input string tag);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, "_ov_drop"},   32'(out_valid), 32'd0);
        check({tag, "_ready_ret"}, 32'(in_ready), 32'd1);
`ifdef FPHUB_DIV_INVALID_FLAG_EN
        check({tag, "_inv_clr"},   32'(invalid), 32'd0);
`endif
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"},  32'(in_ready), 32'd1);
        check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_iter_en"},   32'(iter_en), 32'd0);
        check({tag, "_iter_cnt"},  32'(iter_cnt), 32'd0);
        check({tag, "_strobes"},   32'({op_load, norm_en}), 32'd0);
        check({tag, "_res"},       32'({res_sel, res_sign}), 32'd0);
`ifdef FPHUB_DIV_INVALID_FLAG_EN
        check({tag, "_invalid"},   32'(invalid), 32'd0);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int   n;
        logic stable_ok, replay_seen;

        //          xs    ys    xc    yc    sel   sign  lat iters inv
        vecs[0]  = '{1'b1, 1'b0, 3'd0, 3'd0, 2'd0, 1'b1, 28, 25, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 3'd1, 3'd6, 2'd1, 1'b1, 3,  0,  1'b0};
        vecs[2]  = '{1'b0, 1'b0, 3'd0, 3'd3, 2'd1, 1'b0, 3,  0,  1'b0};
        vecs[3]  = '{1'b1, 1'b1, 3'd4, 3'd0, 2'd2, 1'b0, 3,  0,  1'b0};
        vecs[4]  = '{1'b1, 1'b0, 3'd3, 3'd4, 2'd1, 1'b1, 3,  0,  1'b1};
        vecs[5]  = '{1'b0, 1'b0, 3'd0, 3'd5, 2'd3, 1'b0, 3,  0,  1'b0};
        vecs[6]  = '{1'b0, 1'b1, 3'd2, 3'd1, 2'd1, 1'b1, 3,  0,  1'b1};
        vecs[7]  = '{1'b0, 1'b1, 3'd7, 3'd7, 2'd0, 1'b1, 28, 25, 1'b0};
        vecs[8]  = '{1'b1, 1'b1, 3'd5, 3'd2, 2'd2, 1'b0, 3,  0,  1'b0};
        vecs[9]  = '{1'b1, 1'b0, 3'd3, 3'd0, 2'd2, 1'b1, 3,  0,  1'b0};
        vecs[10] = '{1'b0, 1'b0, 3'd1, 3'd3, 2'd1, 1'b0, 3,  0,  1'b0};
        vecs[11] = '{1'b1, 1'b0, 3'd7, 3'd6, 2'd3, 1'b1, 3,  0,  1'b0};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        x_sign = 1'b0; y_sign = 1'b0; x_sc = 3'd0; y_sc = 3'd0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            run_to_done(vecs[i], $sformatf("vec%0d", i));
            handshake($sformatf("vec%0d", i));
        end

        // Back-pressure: result held for 10 cycles while in_valid pulses are ignored.
        run_to_done(vecs[1], "bp");
        stable_ok = 1'b1;
        for (int c = 0; c < 10; c++) begin
            if (out_valid !== 1'b1 || res_sel !== 2'd1 || res_sign !== 1'b1 || in_ready !== 1'b0
                || op_load !== 1'b0 || iter_en !== 1'b0) stable_ok = 1'b0;
            in_valid = c[0];
            x_sc = 3'd0; y_sc = 3'd0; x_sign = 1'b0; y_sign = 1'b0;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        check("bp_stable", 32'(stable_ok), 32'd1);
        check("bp_held_sel", 32'({out_valid, res_sel, res_sign}), 32'b1011);
        handshake("bp");
        @(posedge clk);
        #1;
        check("bp_no_stale_load", 32'({op_load, out_valid}), 32'd0);

        // Abort mid-iteration with an asynchronous reset.
        start_pair(1'b0, 1'b0, 3'd0, 3'd0);
        n = 0;
        while (iter_cnt !== 5'd12 && n < 60) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("abort_reach_12", 32'(iter_cnt), 32'd12);
        check("abort_iter_en", 32'(iter_en), 32'd1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("abort");
        @(negedge clk);
        rst_n = 1'b1;
        replay_seen = 1'b0;
        for (int c = 0; c < 30; c++) begin
            @(posedge clk);
            #1;
            if (out_valid !== 1'b0 || iter_en !== 1'b0 || in_ready !== 1'b1) replay_seen = 1'b1;
        end
        check("abort_no_replay", 32'(replay_seen), 32'd0);
        run_to_done(vecs[5], "post_abort");
        handshake("post_abort");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
